mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 127 ++++++++++++
 tb/tb_mem_master.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Single-outstanding memory request master: issues a command to the memory
// stage, retries on error, times out on a missing ack, and returns a response.
module mem_master #(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [7:0]  cmd_addr,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [2:0]  rsp_retries
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t      state;
  logic        lat_read;
  logic [7:0]  tcnt;
  logic [2:0]  rcnt;
  logic [8:0]  tnext;

  assign cmd_ready = (state == IDLE);

  // One bit wider so the TIMEOUT=255 compare cannot wrap.
  always_comb begin
    tnext = {1'b0, tcnt} + 9'd1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      lat_read    <= 1'b0;
      tcnt        <= '0;
      rcnt        <= '0;
      mem_req     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_status  <= ST_OK;
      rsp_retries <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_read  <= cmd_read;
            mem_addr  <= cmd_addr;
            tcnt      <= '0;
            rcnt      <= '0;
            mem_req   <= 1'b1;
            mem_read  <= cmd_read;
            mem_write <= ~cmd_read;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!mem_err) begin
              rsp_data    <= lat_read ? mem_data : '0;
              rsp_status  <= ST_OK;
              rsp_retries <= rcnt;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else if (rcnt < 3'(MAX_RETRY) && rcnt != '1) begin
              rcnt  <= rcnt + 3'd1;
              state <= GAP;
            end else begin
              rsp_data    <= '0;
              rsp_status  <= ST_ERR;
              rsp_retries <= rcnt;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end else begin
            if (tcnt != '1) tcnt <= tcnt + 8'd1;
            if (tnext >= 9'(TIMEOUT)) begin
              mem_req     <= 1'b0;
              mem_read    <= 1'b0;
              mem_write   <= 1'b0;
              rsp_data    <= '0;
              rsp_status  <= ST_TIMEOUT;
              rsp_retries <= rcnt;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
        end
        GAP: begin
          tcnt      <= '0;
          mem_req   <= 1'b1;
          mem_read  <= lat_read;
          mem_write <= ~lat_read;
          state     <= REQ;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a scripted memory responder, a protocol
// monitor, and one task per scenario comparing responses against queued expectations.
module tb_mem_master;
  localparam int unsigned TIMEOUT   = 15;
  localparam int unsigned MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [7:0]  cmd_addr;
  logic        mem_req, mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic        mem_ack, mem_err;
  logic [31:0] mem_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_retries;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic [2:0]  r;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // responder configuration (written by tests) and private state
  int          ack_delay = 0;
  int          err_until = 0;
  logic [31:0] rd_data   = '0;
  int          late_seq  = 0;
  int          ack_total = 0;
  int          late_seen = 0;
  int          hi        = 0;

  // monitor state
  logic [7:0] exp_addr   = '0;
  logic       exp_read   = 1'b0;
  int         req_count  = 0;
  int         last_len   = 0;
  int         gap1_count = 0;
  int         viol       = 0;
  int         hi_run     = 0;
  int         idle_run   = 0;
  logic       prev_req   = 1'b0;

  mem_master #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_data(mem_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_retries(rsp_retries)
  );

  always #5 clk = ~clk;

  // Memory stage: ack after ack_delay cycles of mem_req (0 = never); the first
  // acks up to err_until carry mem_err. late_seq bumps inject one stray ack.
  initial begin
    mem_ack = 1'b0; mem_err = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_err = 1'b0; mem_data = '0;
      if (late_seen != late_seq) begin
        late_seen = late_seq;
        hi        = 0;
        mem_ack   = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        hi++;
        if (ack_delay != 0 && hi == ack_delay) begin
          mem_ack   = 1'b1;
          mem_err   = (ack_total < err_until);
          mem_data  = mem_err ? 32'h0BAD_0BAD : rd_data;
          ack_total++;
        end
      end else begin
        hi = 0;
      end
    end
  end

  // Protocol monitor: request count, lengths, single-cycle gaps, signal rules.
  initial begin
    forever begin
      @(negedge clk);
      if ((mem_read && mem_write) || (!mem_req && (mem_read || mem_write)) ||
          (mem_req && (mem_addr !== exp_addr || mem_read !== exp_read || mem_write !== !exp_read)))
        viol++;
      if (mem_req && !prev_req) begin
        req_count++;
        if (idle_run == 1) gap1_count++;
      end
      if (!mem_req && prev_req) last_len = hi_run;
      if (mem_req) begin
        hi_run   = prev_req ? hi_run + 1 : 1;
        idle_run = 0;
      end else begin
        hi_run   = 0;
        idle_run++;
      end
      prev_req = mem_req;
    end
  end

  task automatic issue(input logic rd, input logic [7:0] a);
    exp_addr  = a;
    exp_read  = rd;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = '0;
  endtask

  task automatic collect(output rsp_t got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got = {rsp_data, rsp_status, rsp_retries};
        ok  = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_read, mem_write, mem_addr, rsp_valid, rsp_data, rsp_status, rsp_retries} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b rd=%b wr=%b addr=%h rv=%b data=%h st=%b rt=%0d, required all zero",
               mem_req, mem_read, mem_write, mem_addr, rsp_valid, rsp_data, rsp_status, rsp_retries);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_read_ok();
    rsp_t got, e; bit ok; int rc;
    rc = req_count; ack_delay = 2; rd_data = 32'h55; err_until = ack_total;
    exp_q.push_back('{d: 32'h55, s: 2'b00, r: 3'd0});
    issue(1'b1, 8'h10);
    checks++;
    if (mem_req !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_accept: mem_req=%b cmd_ready=%b, required 1/0", mem_req, cmd_ready);
    end
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL read_ok_rsp: got %h/%b/%0d ok=%0d, required %h/%b/%0d", got.d, got.s, got.r, ok, e.d, e.s, e.r);
    end
    checks++;
    if (req_count - rc != 1 || last_len != 2) begin
      errors++;
      $display("FAIL read_ok_reqs: count=%0d len=%0d, required 1/2", req_count - rc, last_len);
    end
  endtask

  task automatic test_write();
    rsp_t got, e; bit ok; int rc, vc;
    rc = req_count; vc = viol; ack_delay = 6; rd_data = 32'hFFFF_FFFF; err_until = ack_total;
    exp_q.push_back('{d: 32'h0, s: 2'b00, r: 3'd0});
    issue(1'b0, 8'h80);
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL write_rsp: got %h/%b/%0d ok=%0d, required %h/%b/%0d", got.d, got.s, got.r, ok, e.d, e.s, e.r);
    end
    checks++;
    if (req_count - rc != 1 || last_len != 6 || viol != vc) begin
      errors++;
      $display("FAIL write_reqs: count=%0d len=%0d viol=%0d, required 1/6/0", req_count - rc, last_len, viol - vc);
    end
  endtask

  task automatic test_err_retry();
    rsp_t got, e; bit ok; int rc, gc;
    rc = req_count; gc = gap1_count; ack_delay = 1; rd_data = 32'h1111; err_until = ack_total + 100;
    exp_q.push_back('{d: 32'h0, s: 2'b01, r: 3'(MAX_RETRY)});
    issue(1'b1, 8'h20);
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL err_retry_rsp: got %h/%b/%0d ok=%0d, required %h/%b/%0d", got.d, got.s, got.r, ok, e.d, e.s, e.r);
    end
    checks++;
    if (req_count - rc != 3 || gap1_count - gc != 2) begin
      errors++;
      $display("FAIL err_retry_reqs: count=%0d gaps1=%0d, required 3/2", req_count - rc, gap1_count - gc);
    end
  endtask

  task automatic test_err_then_ok();
    rsp_t got, e; bit ok; int rc;
    rc = req_count; ack_delay = 1; rd_data = 32'h7F; err_until = ack_total + 1;
    exp_q.push_back('{d: 32'h7F, s: 2'b00, r: 3'd1});
    issue(1'b1, 8'h40);
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL err_then_ok_rsp: got %h/%b/%0d ok=%0d, required %h/%b/%0d", got.d, got.s, got.r, ok, e.d, e.s, e.r);
    end
    checks++;
    if (req_count - rc != 2) begin
      errors++;
      $display("FAIL err_then_ok_reqs: count=%0d, required 2", req_count - rc);
    end
  endtask

  task automatic test_timeout();
    rsp_t got, e; bit ok; int rc;
    rc = req_count; ack_delay = 0; err_until = ack_total; rsp_ready = 1'b0;
    exp_q.push_back('{d: 32'h0, s: 2'b10, r: 3'd0});
    issue(1'b1, 8'h33);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wait: rsp_valid=%b, required 1 within 100 cycles", rsp_valid);
    end
    @(posedge clk); #1;
    late_seq++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_data !== 32'h0 || last_len != int'(TIMEOUT)) begin
      errors++;
      $display("FAIL timeout_hold: rv=%b st=%b data=%h len=%0d, required 1/10/0/%0d",
               rsp_valid, rsp_status, rsp_data, last_len, TIMEOUT);
    end
    rsp_ready = 1'b1;
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL timeout_rsp: got %h/%b/%0d ok=%0d, required %h/%b/%0d", got.d, got.s, got.r, ok, e.d, e.s, e.r);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || req_count - rc != 1) begin
      errors++;
      $display("FAIL timeout_late_ack: cmd_ready=%b rv=%b count=%0d, required 1/0/1", cmd_ready, rsp_valid, req_count - rc);
    end
  endtask

  task automatic test_back_to_back();
    rsp_t got, e; bit ok;
    logic [31:0] pat [3];
    pat[0] = 32'hA5A5_0001; pat[1] = 32'h5A5A_0002; pat[2] = 32'h0F0F_0003;
    ack_delay = 1; err_until = ack_total;
    for (int unsigned k = 0; k < 3; k++) begin
      rd_data = pat[k];
      exp_q.push_back('{d: pat[k], s: 2'b00, r: 3'd0});
      issue(1'b1, 8'(8'hC0 + k));
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: rv=%b mem_req=%b, required 1/0", k, rsp_valid, mem_req);
      end
      collect(got, ok); e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: got %h/%b/%0d ok=%0d, required %h/%b/%0d", k, got.d, got.s, got.r, ok, e.d, e.s, e.r);
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_t got, e; bit ok, stray, unstable; int rc;
    ack_delay = 0; err_until = ack_total;
    issue(1'b1, 8'h30);
    repeat (2) @(posedge clk);
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_read !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid_async: req=%b rd=%b rv=%b cmd_ready=%b addr=%h, required 0/0/0/1/00",
               mem_req, mem_read, rsp_valid, cmd_ready, mem_addr);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_mid_stale: stray response or request seen=%b, required 0", stray);
    end
    @(posedge clk); #1;
    rc = req_count; ack_delay = 2; rd_data = 32'h1234; rsp_ready = 1'b0;
    exp_q.push_back('{d: 32'h1234, s: 2'b00, r: 3'd0});
    issue(1'b1, 8'h05);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    unstable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_data, rsp_status, rsp_retries} !== exp_q[0]) unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL reset_mid_hold: rv=%b data=%h st=%b rt=%0d, required stable 1/%h/%b/%0d",
               rsp_valid, rsp_data, rsp_status, rsp_retries, exp_q[0].d, exp_q[0].s, exp_q[0].r);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    collect(got, ok); e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e || req_count - rc != 1) begin
      errors++;
      $display("FAIL reset_mid_rsp: got %h/%b/%0d ok=%0d count=%0d, required %h/%b/%0d count 1",
               got.d, got.s, got.r, ok, req_count - rc, e.d, e.s, e.r);
    end
  endtask

  initial begin
    test_reset();
    test_read_ok();
    test_write();
    test_err_retry();
    test_err_then_ok();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (viol != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL protocol_final: violations=%0d pending=%0d, required 0/0", viol, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
